// File: rtl/rs_dec_syndrome_calc_p.sv
// RS syndrome calculator over GF(2^8), poly 0x11D: Horner accumulation of NSYM syndromes over N symbols.
// Optional macro RS_SYN_RX_TOGGLE_SYNC_EN: i_rx_en becomes a cross-domain toggle, synchronised internally.
module rs_dec_syndrome_calc_p #(
    parameter int N    = 32,
    parameter int NSYM = 4,
    parameter int FCR  = 0
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_start,
    input  logic [7:0]        i_rx,
    input  logic              i_rx_en,
    output logic [8*NSYM-1:0] o_syn,
    output logic              o_ready,
    output logic              o_zero,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [8*NSYM-1:0] acc, acc_n, acc_mul;
    logic              zero_q, zero_n;
    logic              ovr_q, ovr_n;
    logic              strobe;

    // Multiply by alpha^k; with a constant k this folds into a fixed XOR network.
    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] a, input int k);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 255; i++) begin
            if (i < (k % 255)) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    for (genvar j = 0; j < NSYM; j++) begin : g_mul
        assign acc_mul[8*j +: 8] = gf_mul_alpha(acc[8*j +: 8], FCR + j);
    end

`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
    // Two synchroniser flops plus one edge-detect flop; each toggle gives one strobe.
    logic [2:0] tog_q;
    always_ff @(posedge i_clk) begin
        if (i_res) tog_q <= 3'b000;
        else       tog_q <= {tog_q[1:0], i_rx_en};
    end
    assign strobe = tog_q[1] ^ tog_q[2];
`else
    assign strobe = i_rx_en;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        ovr_n   = 1'b0;
        if (i_start) begin
            state_n = ACC;
            cnt_n   = '0;
            acc_n   = '0;
            if (strobe) begin
                acc_n = {NSYM{i_rx}};
                cnt_n = CW'(1);
                if (N == 1) state_n = DONE;
            end
        end else begin
            case (state)
                ACC: begin
                    if (strobe) begin
                        acc_n = acc_mul ^ {NSYM{i_rx}};
                        cnt_n = cnt + 1'b1;
                        if (cnt == CW'(N - 1)) state_n = DONE;
                    end
                end
                default: begin
                    if (strobe) ovr_n = 1'b1;
                end
            endcase
        end
        // Registered alongside the DONE transition so it is valid with o_ready.
        zero_n = (state_n == DONE) && (acc_n == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            zero_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            zero_q <= zero_n;
            ovr_q  <= ovr_n;
        end
    end

    assign o_syn     = acc;
    assign o_ready   = (state == DONE);
    assign o_zero    = zero_q;
    assign o_busy    = (state == ACC);
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_rs_dec_syndrome_calc_p.sv
// Directed bench for rs_dec_syndrome_calc_p (N=32, NSYM=4, FCR=0); also covers RS_SYN_RX_TOGGLE_SYNC_EN builds.
module tb_rs_dec_syndrome_calc_p;

    logic        i_clk = 1'b0;
    logic        i_res, i_start, i_rx_en;
    logic [7:0]  i_rx;
    logic [31:0] o_syn;
    logic        o_ready, o_zero, o_busy, o_overrun;

    int checks = 0;
    int passed = 0;
    logic [7:0] frame [32];

    rs_dec_syndrome_calc_p #(.N(32), .NSYM(4), .FCR(0)) dut (
        .i_clk(i_clk), .i_res(i_res), .i_start(i_start), .i_rx(i_rx), .i_rx_en(i_rx_en),
        .o_syn(o_syn), .o_ready(o_ready), .o_zero(o_zero), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // One symbol strobe; returns right after the edge that consumes it.
    task automatic strobe(input logic [7:0] v);
        i_rx = v;
`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
        i_rx_en = ~i_rx_en;
        repeat (3) tick();
`else
        i_rx_en = 1'b1;
        tick();
        i_rx_en = 1'b0;
`endif
    endtask

    task automatic send_sym(input logic [7:0] v);
        strobe(v);
`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
        tick();
`endif
    endtask

    task automatic do_start;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic start_with_sym(input logic [7:0] v);
        i_rx = v;
`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
        i_rx_en = ~i_rx_en;
        repeat (2) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
`else
        i_start = 1'b1;
        i_rx_en = 1'b1;
        tick();
        i_start = 1'b0;
        i_rx_en = 1'b0;
`endif
    endtask

    task automatic clear_frame;
        for (int i = 0; i < 32; i++) frame[i] = 8'h00;
    endtask

    // Sends frame[first..31]; checks o_ready rises exactly on the last accept edge.
    task automatic run_frame(input int first, input logic [31:0] exp_syn, input logic exp_zero);
        for (int i = first; i < 31; i++) send_sym(frame[i]);
        checks++; if (o_ready !== 1'b0) $display("FAIL early_ready got %b want 0", o_ready); else passed++;
        checks++; if (o_busy !== 1'b1) $display("FAIL acc_busy got %b want 1", o_busy); else passed++;
        strobe(frame[31]);
        checks++; if (o_ready !== 1'b1) $display("FAIL ready got %b want 1", o_ready); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL done_busy got %b want 0", o_busy); else passed++;
        checks++; if (o_syn !== exp_syn) $display("FAIL syn got %h want %h", o_syn, exp_syn); else passed++;
        checks++; if (o_zero !== exp_zero) $display("FAIL zero got %b want %b", o_zero, exp_zero); else passed++;
`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
        tick();
`endif
    endtask

    task automatic test_reset;
        i_res = 1'b1; i_start = 1'b0; i_rx_en = 1'b0; i_rx = 8'h00;
        repeat (2) tick();
        checks++; if (o_syn !== 32'h0) $display("FAIL rst_syn got %h want 0", o_syn); else passed++;
        checks++; if (o_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", o_ready); else passed++;
        checks++; if (o_zero !== 1'b0) $display("FAIL rst_zero got %b want 0", o_zero); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", o_busy); else passed++;
        checks++; if (o_overrun !== 1'b0) $display("FAIL rst_ovr got %b want 0", o_overrun); else passed++;
        i_res = 1'b0;
        tick();
    endtask

    task automatic test_all_zero;
        do_start();
        checks++; if (o_busy !== 1'b1) $display("FAIL start_busy got %b want 1", o_busy); else passed++;
        clear_frame();
        run_frame(0, 32'h0000_0000, 1'b1);
    endtask

    task automatic test_r1;
        do_start();
        checks++; if (o_ready !== 1'b0) $display("FAIL restart_ready got %b want 0", o_ready); else passed++;
        checks++; if (o_zero !== 1'b0) $display("FAIL restart_zero got %b want 0", o_zero); else passed++;
        checks++; if (o_syn !== 32'h0) $display("FAIL restart_syn got %h want 0", o_syn); else passed++;
        clear_frame();
        frame[30] = 8'h01;
        run_frame(0, 32'h0804_0201, 1'b0);
    endtask

    task automatic test_r0_overrun;
        do_start();
        clear_frame();
        frame[31] = 8'h05;
        run_frame(0, 32'h0505_0505, 1'b0);
        strobe(8'h77);
        checks++; if (o_overrun !== 1'b1) $display("FAIL ovr_pulse got %b want 1", o_overrun); else passed++;
        checks++; if (o_syn !== 32'h0505_0505) $display("FAIL ovr_syn got %h want 05050505", o_syn); else passed++;
        checks++; if (o_ready !== 1'b1) $display("FAIL ovr_ready got %b want 1", o_ready); else passed++;
        tick();
        checks++; if (o_overrun !== 1'b0) $display("FAIL ovr_width got %b want 0", o_overrun); else passed++;
    endtask

    task automatic test_restart_paired;
        logic [7:0] junk [10];
        junk = '{8'h3C, 8'hA5, 8'h11, 8'hFF, 8'h80, 8'h07, 8'h5A, 8'hC3, 8'h21, 8'h9E};
        do_start();
        for (int i = 0; i < 10; i++) send_sym(junk[i]);
        checks++; if (o_syn === 32'h0) $display("FAIL partial_syn got %h want nonzero", o_syn); else passed++;
        start_with_sym(8'h00);
        clear_frame();
        frame[30] = 8'h01;
        run_frame(1, 32'h0804_0201, 1'b0);
    endtask

    task automatic test_r8_and_r1r0;
        do_start();
        clear_frame();
        frame[23] = 8'h01;
        run_frame(0, 32'h8F4C_1D01, 1'b0);
        do_start();
        clear_frame();
        frame[30] = 8'h01;
        frame[31] = 8'h01;
        run_frame(0, 32'h0905_0300, 1'b0);
    endtask

    task automatic test_mid_reset;
        do_start();
        for (int i = 0; i < 15; i++) send_sym(8'h11);
        i_rx = 8'h22;
`ifndef RS_SYN_RX_TOGGLE_SYNC_EN
        i_rx_en = 1'b1;
`endif
        i_res = 1'b1;
        tick();
        i_res = 1'b0;
        i_rx_en = 1'b0;
        checks++; if (o_syn !== 32'h0) $display("FAIL mrst_syn got %h want 0", o_syn); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", o_busy); else passed++;
        checks++; if (o_ready !== 1'b0) $display("FAIL mrst_ready got %b want 0", o_ready); else passed++;
        repeat (6) tick();
        strobe(8'h33);
        checks++; if (o_overrun !== 1'b1) $display("FAIL idle_ovr got %b want 1", o_overrun); else passed++;
        checks++; if (o_syn !== 32'h0) $display("FAIL idle_syn got %h want 0", o_syn); else passed++;
        tick();
    endtask

`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
    task automatic test_toggle_latency;
        do_start();
        for (int i = 0; i < 30; i++) send_sym(8'h00);
        i_rx = 8'h01;
        i_rx_en = ~i_rx_en;
        repeat (2) tick();
        checks++; if (o_syn[7:0] !== 8'h00) $display("FAIL tog_early got %h want 00", o_syn[7:0]); else passed++;
        tick();
        checks++; if (o_syn[7:0] !== 8'h01) $display("FAIL tog_lat got %h want 01", o_syn[7:0]); else passed++;
        tick();
        strobe(8'h00);
        checks++; if (o_syn !== 32'h0804_0201) $display("FAIL tog_syn got %h want 08040201", o_syn); else passed++;
        checks++; if (o_ready !== 1'b1) $display("FAIL tog_ready got %b want 1", o_ready); else passed++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_all_zero();
        test_r1();
        test_r0_overrun();
        test_restart_paired();
        test_r8_and_r1r0();
        test_mid_reset();
`ifdef RS_SYN_RX_TOGGLE_SYNC_EN
        test_toggle_latency();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
